// File: rtl/phase_timer_pkg.sv
// Shared types and helpers for the phase timer controller.
package phase_timer_pkg;

  typedef enum logic [2:0] {
    PH_IDLE = 3'd0,
    PH_P0   = 3'd1,
    PH_P1   = 3'd2,
    PH_P2   = 3'd3,
    PH_P3   = 3'd4
  } phase_e;

  localparam int unsigned PH_NUM = 4;

  // LSB of the duration slice for a phase; IDLE has no slice and maps to 0.
  function automatic int unsigned dur_lsb(input phase_e ph, input int unsigned w);
    return (ph == PH_IDLE) ? 0 : (32'(ph) - 32'd1) * w;
  endfunction

endpackage

// File: rtl/phase_timer_edge_det.sv
// Toggle detector for event inputs; PHASE_TIMER_CTRL_EV_SYNC_EN inserts a
// 2-flop synchroniser ahead of the detector.
module phase_timer_edge_det #(
  parameter int unsigned NCH = 2
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [NCH-1:0] ev_in,
  input  logic [NCH-1:0] ev_mask,
  output logic [NCH-1:0] ev_edge,
  output logic           ev_any
);

  logic [NCH-1:0] src;
  logic [NCH-1:0] ev_q;

`ifdef PHASE_TIMER_CTRL_EV_SYNC_EN
  logic [NCH-1:0] sync1;
  logic [NCH-1:0] sync2;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= ev_in;
      sync2 <= sync1;
    end
  end

  assign src = sync2;
`else
  assign src = ev_in;
`endif

  always_ff @(posedge clk) begin
    if (rst) ev_q <= '0;
    else     ev_q <= src;
  end

  assign ev_edge = src ^ ev_q;
  assign ev_any  = |(ev_edge & ev_mask);

endmodule

// File: rtl/phase_timer_ctrl.sv
// Prescaled four-phase timer with programmable durations and event-forced steps.
// Build option: PHASE_TIMER_CTRL_EV_SYNC_EN (synchronise ev_in, see edge detector).
module phase_timer_ctrl
  import phase_timer_pkg::*;
#(
  parameter int unsigned PRE_W  = 4,
  parameter int unsigned PRE_TC = 10,
  parameter int unsigned CNT_W  = 5,
  parameter int unsigned NCH    = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NCH-1:0]            ev_in,
  input  logic [NCH-1:0]            ev_mask,
  input  logic                      start,
  input  logic                      stop,
  input  logic [PH_NUM*CNT_W-1:0]   dur_i,
  output logic [2:0]                phase_o,
  output logic                      phase_tick_o,
  output logic [CNT_W-1:0]          cnt_o,
  output logic [NCH-1:0]            ev_seen_o
);

  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PRE_TC);

  phase_e           phase;
  phase_e           phase_nx;
  logic [PRE_W-1:0] pre;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] dur_lat;
  logic [CNT_W-1:0] dur_nx;
  logic [NCH-1:0]   ev_edge;
  logic             ev_any;
  logic             pre_tick;
  logic             step;
  logic             term;
  logic             enter_p0;
  logic             tick;
  logic [NCH-1:0]   seen;

  phase_timer_edge_det #(
    .NCH (NCH)
  ) u_edge (
    .clk     (clk),
    .rst     (rst),
    .ev_in   (ev_in),
    .ev_mask (ev_mask),
    .ev_edge (ev_edge),
    .ev_any  (ev_any)
  );

  always_ff @(posedge clk) begin
    if (rst)                  pre <= '0;
    else if (pre == PRE_LAST) pre <= '0;
    else                      pre <= pre + 1'b1;
  end

  assign pre_tick = (pre == PRE_LAST);
  assign step     = pre_tick | ev_any;
  assign term     = step && (cnt == dur_lat);

  always_comb begin
    phase_nx = PH_IDLE;
    unique case (phase)
      PH_P0:   phase_nx = PH_P1;
      PH_P1:   phase_nx = PH_P2;
      PH_P2:   phase_nx = PH_P3;
      PH_P3:   phase_nx = start ? PH_P0 : PH_IDLE;
      default: phase_nx = PH_IDLE;
    endcase
  end

  assign dur_nx   = dur_i[dur_lsb(phase_nx, CNT_W) +: CNT_W];
  assign enter_p0 = !stop && start &&
                    ((phase == PH_IDLE) || (phase == PH_P3 && term));

  always_ff @(posedge clk) begin
    if (rst) begin
      phase   <= PH_IDLE;
      cnt     <= '0;
      dur_lat <= '0;
      tick    <= 1'b0;
    end else begin
      tick <= 1'b0;
      if (stop) begin
        // Tick only on an actual phase change, so stop while IDLE is silent.
        phase <= PH_IDLE;
        cnt   <= '0;
        tick  <= (phase != PH_IDLE);
      end else begin
        unique case (phase)
          PH_IDLE: begin
            cnt <= '0;
            if (start) begin
              phase   <= PH_P0;
              dur_lat <= dur_i[0 +: CNT_W];
              tick    <= 1'b1;
            end
          end
          default: begin
            if (term) begin
              phase <= phase_nx;
              cnt   <= '0;
              tick  <= 1'b1;
              if (phase_nx != PH_IDLE) dur_lat <= dur_nx;
            end else if (step) begin
              cnt <= cnt + 1'b1;
            end
          end
        endcase
      end
    end
  end

  // A fresh edge on the P0 entry cycle survives the clear.
  always_ff @(posedge clk) begin
    if (rst) seen <= '0;
    else     seen <= (enter_p0 ? '0 : seen) | ev_edge;
  end

  assign phase_o      = phase;
  assign phase_tick_o = tick;
  assign cnt_o        = cnt;
  assign ev_seen_o    = seen;

endmodule

// File: tb/tb_phase_timer_ctrl.sv
// Randomised and directed bench for phase_timer_ctrl against a cycle-level
// behavioural model of the phase/step rules.
module tb_phase_timer_ctrl;

  localparam int unsigned PRE_W  = 4;
  localparam int unsigned PRE_TC = 10;
  localparam int unsigned CNT_W  = 5;
  localparam int unsigned NCH    = 2;
`ifdef PHASE_TIMER_CTRL_EV_SYNC_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 1;
`endif

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic [NCH-1:0]       ev_in = '0;
  logic [NCH-1:0]       ev_mask = '1;
  logic                 start = 1'b0;
  logic                 stop = 1'b0;
  logic [4*CNT_W-1:0]   dur_i = '0;
  logic [2:0]           phase_o;
  logic                 phase_tick_o;
  logic [CNT_W-1:0]     cnt_o;
  logic [NCH-1:0]       ev_seen_o;

  phase_timer_ctrl #(
    .PRE_W  (PRE_W),
    .PRE_TC (PRE_TC),
    .CNT_W  (CNT_W),
    .NCH    (NCH)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .ev_in        (ev_in),
    .ev_mask      (ev_mask),
    .start        (start),
    .stop         (stop),
    .dur_i        (dur_i),
    .phase_o      (phase_o),
    .phase_tick_o (phase_tick_o),
    .cnt_o        (cnt_o),
    .ev_seen_o    (ev_seen_o)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input int unsigned got, input int unsigned exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Behavioural model: phase numbers 0..4, plain integer counters.
  int             m_pre, m_ph, m_cnt, m_dur;
  bit             m_tick;
  logic [NCH-1:0] m_s1, m_s2, m_evq, m_seen;

  function automatic int dur_of(input int k);
    logic [4*CNT_W-1:0] t;
    t = dur_i >> (k * CNT_W);
    return int'(t[CNT_W-1:0]);
  endfunction

  task automatic model_step();
    logic [NCH-1:0] src, edg;
    bit step, enter0;
    int nph, ncnt, ndur;
    if (rst) begin
      m_pre = 0; m_ph = 0; m_cnt = 0; m_dur = 0; m_tick = 0;
      m_s1 = '0; m_s2 = '0; m_evq = '0; m_seen = '0;
      return;
    end
    src    = (LAT == 3) ? m_s2 : ev_in;
    edg    = src ^ m_evq;
    step   = (m_pre == PRE_TC) || (|(edg & ev_mask));
    nph    = m_ph; ncnt = m_cnt; ndur = m_dur; enter0 = 0;
    if (stop) begin
      nph = 0; ncnt = 0;
    end else if (m_ph == 0) begin
      if (start) begin nph = 1; ncnt = 0; ndur = dur_of(0); enter0 = 1; end
    end else if (step) begin
      if (m_cnt == m_dur) begin
        nph  = (m_ph < 4) ? m_ph + 1 : (start ? 1 : 0);
        ncnt = 0;
        if (nph != 0) ndur = dur_of(nph - 1);
        enter0 = (nph == 1);
      end else begin
        ncnt = m_cnt + 1;
      end
    end
    m_tick = (nph != m_ph);
    m_seen = (enter0 ? '0 : m_seen) | edg;
    m_ph = nph; m_cnt = ncnt; m_dur = ndur;
    m_s2 = m_s1; m_s1 = ev_in; m_evq = src;
    m_pre = (m_pre == PRE_TC) ? 0 : m_pre + 1;
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
    check("phase", phase_o, m_ph);
    check("cnt", cnt_o, m_cnt);
    check("tick", phase_tick_o, m_tick);
    check("seen", ev_seen_o, m_seen);
  endtask

  task automatic wait_phase(input int ph, input int budget, input string tag);
    int n = 0;
    while (phase_o != ph && n < budget) begin cycle(); n++; end
    if (phase_o != ph) check({tag, "_timeout"}, phase_o, ph);
  endtask

  initial begin
    int len, nchg, idx, c0, n, last;
    int exp_len [5] = '{22, 11, 44, 33, 22};

    // Basic cycling: durations 2,1,0,3 -> 33,22,11,44 cycle phases
    dur_i = {5'd3, 5'd0, 5'd1, 5'd2};
    cycle(); cycle();
    check("rst_phase", phase_o, 0);
    check("rst_cnt", cnt_o, 0);
    rst = 1'b0; start = 1'b1;
    last = 0; len = 0; nchg = 0; idx = 0; n = 0;
    while (idx < 5 && n < 800) begin
      cycle(); n++;
      if (phase_o != last) begin
        if (nchg >= 2) begin check("phase_len", len, exp_len[idx]); idx++; end
        nchg++; len = 1; last = phase_o;
      end else len++;
    end
    if (idx < 5) check("len_timeout", idx, 5);

    // Event steps in P1 with dur 5, away from the prescaler tick
    dur_i = {5'd1, 5'd1, 5'd5, 5'd0};
    n = 0;
    while (!(phase_o == 2 && cnt_o == 1 && m_dur == 5 && m_pre <= PRE_TC - LAT - 2) && n < 400) begin
      cycle(); n++;
    end
    check("p1_setup", (phase_o == 2 && cnt_o == 1) ? 1 : 0, 1);
    for (int j = 0; j < LAT + 2; j++) begin
      int k;
      if (j < 3) ev_in[0] = ~ev_in[0];
      cycle();
      k = j - LAT + 2;
      if (k < 0) k = 0;
      if (k > 3) k = 3;
      check("ev_step", cnt_o, 1 + k);
    end
    check("seen0", ev_seen_o[0], 1);

    // Event coinciding with the prescaler tick: one step only
    n = 0;
    while (m_pre != PRE_TC - (LAT - 1) && n < 20) begin cycle(); n++; end
    c0 = cnt_o;
    ev_in[0] = ~ev_in[0];
    for (int j = 0; j < LAT; j++) cycle();
    check("coincide", cnt_o, c0 + 1);

    // Masked channel: flagged but no step; flag cleared at next P0 entry
    ev_mask = 2'b01;
    c0 = cnt_o;
    ev_in[1] = ~ev_in[1];
    for (int j = 0; j < LAT + 1; j++) cycle();
    check("masked_cnt", cnt_o, c0);
    check("masked_seen", ev_seen_o[1], 1);
    wait_phase(1, 400, "p0_entry");
    check("seen_clr", ev_seen_o, 0);
    ev_mask = 2'b11;

    // Stop in P2
    wait_phase(3, 400, "p2");
    stop = 1'b1;
    cycle();
    check("stop_phase", phase_o, 0);
    check("stop_cnt", cnt_o, 0);
    check("stop_tick", phase_tick_o, 1);
    cycle();
    check("stop_idle_tick", phase_tick_o, 0);
    stop = 1'b0;

    // Reset mid-P3
    wait_phase(4, 400, "p3");
    rst = 1'b1;
    cycle();
    check("rst3_phase", phase_o, 0);
    check("rst3_cnt", cnt_o, 0);
    check("rst3_tick", phase_tick_o, 0);
    check("rst3_seen", ev_seen_o, 0);

    // ev_in high across reset: one spurious edge, which only lands in P0
    // (and so steps) when the synchroniser delays it past the IDLE cycle
    ev_in = '1; dur_i = {5'd3, 5'd3, 5'd3, 5'd31};
    cycle();
    rst = 1'b0;
    for (int j = 0; j < 6; j++) cycle();
    check("rst_edge_steps", cnt_o, (LAT == 3) ? 1 : 0);

    // Randomised run against the model
    for (int i = 0; i < 3000; i++) begin
      rst  = ($urandom % 200) == 0;
      stop = ($urandom % 60) == 0;
      if (($urandom % 50) == 0) start = ~start;
      for (int b = 0; b < NCH; b++)
        if (($urandom % 6) == 0) ev_in[b] = ~ev_in[b];
      if (($urandom % 40) == 0) ev_mask = NCH'($urandom);
      if (($urandom % 25) == 0)
        dur_i = {5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3))};
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
